mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the MIPS core's fetch and data ports onto one
// request/acknowledge memory, with a per-access watchdog and sticky error.
// Optional feature macro: ARB_FAIR_EN (alternating tie-break between ports).
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic            take_i, take_d;
    logic            tmo_c;
    logic            tie_data_c;

`ifdef ARB_FAIR_EN
    // 1 = data port received the most recent grant
    logic last_d_q, last_d_d;

    // Ties go to the port not served last
    always_comb tie_data_c = ~last_d_q;
`else
    // Ties always go to the data port
    always_comb tie_data_c = 1'b1;
`endif

    // Next-state, grant latching, watchdog and per-port ready/rdata
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = 32'd0;
        d_rdata = 32'd0;
        take_i  = 1'b0;
        take_d  = 1'b0;
        tmo_c   = (wd_q == WD_W'(TIMEOUT - 1)) && !m_ack;
`ifdef ARB_FAIR_EN
        last_d_d = last_d_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || tie_data_c)) begin
                    take_d = 1'b1;
                end else if (i_req) begin
                    take_i = 1'b1;
                end
            end
            IBUSY: begin
                if (m_ack) begin
                    i_ready = 1'b1;
                    i_rdata = m_rdata;
                    take_d  = d_req;
                end else if (tmo_c) begin
                    i_ready = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DBUSY: begin
                if (m_ack) begin
                    d_ready = 1'b1;
                    d_rdata = m_rdata;
                    take_i  = i_req;
                end else if (tmo_c) begin
                    d_ready = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_d) begin
            state_d = DBUSY;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            wd_d    = '0;
`ifdef ARB_FAIR_EN
            last_d_d = 1'b1;
`endif
        end else if (take_i) begin
            state_d = IBUSY;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = 32'd0;
            wd_d    = '0;
`ifdef ARB_FAIR_EN
            last_d_d = 1'b0;
`endif
        end else if ((state_q != IDLE) && (m_ack || tmo_c)) begin
            state_d = IDLE;
            we_d    = 1'b0;
            wdata_d = 32'd0;
            wd_d    = '0;
        end
    end

    // State, latched memory fields, watchdog and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wd_q    <= '0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

`ifdef ARB_FAIR_EN
    // Last-grant register, resets to the fetch port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    // Memory-side outputs are direct decodes of registered state
    always_comb begin
        m_req   = (state_q != IDLE);
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle tables, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_irdy;
        logic [31:0] e_irdata;
        logic        e_drdy;
        logic [31:0] e_drdata;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
        input logic ma, input logic [31:0] mr,
        input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emwd,
        input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia;
        v.d_req = dr;  v.d_we = dw;  v.d_addr = da;  v.d_wdata = dwd;
        v.m_ack = ma;  v.m_rdata = mr;
        v.e_mreq = emr; v.e_mwe = emw; v.e_maddr = ema; v.e_mwdata = emwd;
        v.e_irdy = eir; v.e_irdata = eird; v.e_drdy = edr; v.e_drdata = edrd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        i_req = v.i_req;  i_addr = v.i_addr;
        d_req = v.d_req;  d_we = v.d_we;  d_addr = v.d_addr;  d_wdata = v.d_wdata;
        m_ack = v.m_ack;  m_rdata = v.m_rdata;
        #1;
        chk($sformatf("v%0d m_req", idx),   32'(m_req),   32'(v.e_mreq));
        chk($sformatf("v%0d m_we", idx),    32'(m_we),    32'(v.e_mwe));
        chk($sformatf("v%0d m_addr", idx),  m_addr,       v.e_maddr);
        chk($sformatf("v%0d m_wdata", idx), m_wdata,      v.e_mwdata);
        chk($sformatf("v%0d i_ready", idx), 32'(i_ready), 32'(v.e_irdy));
        chk($sformatf("v%0d i_rdata", idx), i_rdata,      v.e_irdata);
        chk($sformatf("v%0d d_ready", idx), 32'(d_ready), 32'(v.e_drdy));
        chk($sformatf("v%0d d_rdata", idx), d_rdata,      v.e_drdata);
        chk($sformatf("v%0d err", idx),     32'(err),     32'd0);
    endtask

    task automatic zero_inputs();
        i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; m_ack = 1'b0; m_rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Transaction-level reference: who owns the memory and for how long
    int          own;       // 0 none, 1 fetch, 2 data
    int          waited;    // busy cycles elapsed without an ack
    bit          err_m;
    bit          last_was_d;
    logic [31:0] a_m, wd_m;
    logic        we_m;

    function automatic int pick_idle(input logic ir, input logic dr);
        bit data_on_tie;
`ifdef ARB_FAIR_EN
        data_on_tie = !last_was_d;
`else
        data_on_tie = 1'b1;
`endif
        if (dr && (!ir || data_on_tie)) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    localparam logic [31:0] IA0 = 32'h0040_0000;
    localparam logic [31:0] IA1 = 32'h0040_0004;
    localparam logic [31:0] DA0 = 32'h1000_0004;
    localparam logic [31:0] DA1 = 32'h1000_0008;
    localparam logic [31:0] DA2 = 32'h1000_000C;
    localparam logic [31:0] DW  = 32'hDEAD_BEEF;

    initial begin
        vec_t vt[$];

        // Reset state, with activity on the inputs
        reset = 1'b0;
        i_req = 1'b1; i_addr = IA0; d_req = 1'b1; d_we = 1'b1;
        d_addr = DA0; d_wdata = DW; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst m_req", 32'(m_req), 32'd0);
        chk("rst m_we", 32'(m_we), 32'd0);
        chk("rst m_addr", m_addr, 32'd0);
        chk("rst m_wdata", m_wdata, 32'd0);
        chk("rst i_ready", 32'(i_ready), 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_ready", 32'(d_ready), 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        zero_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Cycle tables: fetch only, store+fetch handoff, idle ack, tie-breaks
        vt.push_back(mk(1,IA0,0,0,0,0, 0,0,                1,0,0,0,   0,0,0,0));
        vt[0].e_mreq = 1'b0;
        vt.push_back(mk(1,IA0,0,0,0,0, 1,32'h2008_0005,    1,0,IA0,0, 1,32'h2008_0005,0,0));
        vt.push_back(mk(0,IA0,0,0,0,0, 0,0,                0,0,IA0,0, 0,0,0,0));
        vt.push_back(mk(1,IA1,1,1,DA0,DW, 0,0,             0,0,IA0,0, 0,0,0,0));
        vt.push_back(mk(1,IA1,1,1,DA0,DW, 0,0,             1,1,DA0,DW, 0,0,0,0));
        vt.push_back(mk(1,IA1,1,1,DA0,DW, 1,32'h1111_1111, 1,1,DA0,DW, 0,0,1,32'h1111_1111));
        vt.push_back(mk(1,IA1,0,0,0,0, 0,0,                1,0,IA1,0, 0,0,0,0));
        vt.push_back(mk(1,IA1,0,0,0,0, 1,32'h2222_2222,    1,0,IA1,0, 1,32'h2222_2222,0,0));
        vt.push_back(mk(0,0,0,0,0,0, 1,32'h3333_3333,      0,0,IA1,0, 0,0,0,0));
        vt.push_back(mk(1,IA1,1,0,DA1,0, 0,0,              0,0,IA1,0, 0,0,0,0));
        vt.push_back(mk(1,IA1,1,0,DA1,0, 1,32'h44,         1,0,DA1,0, 0,0,1,32'h44));
        vt.push_back(mk(1,IA1,0,0,0,0, 1,32'h55,           1,0,IA1,0, 1,32'h55,0,0));
        vt.push_back(mk(0,0,1,0,DA2,0, 0,0,                0,0,IA1,0, 0,0,0,0));
        vt.push_back(mk(0,0,1,0,DA2,0, 1,32'h66,           1,0,DA2,0, 0,0,1,32'h66));
        vt.push_back(mk(1,IA0,1,0,DA2,0, 0,0,              0,0,DA2,0, 0,0,0,0));
`ifdef ARB_FAIR_EN
        vt.push_back(mk(1,IA0,1,0,DA2,0, 1,32'h77,         1,0,IA0,0, 1,32'h77,0,0));
        vt.push_back(mk(0,IA0,1,0,DA2,0, 1,32'h88,         1,0,DA2,0, 0,0,1,32'h88));
        vt.push_back(mk(0,0,0,0,0,0, 0,0,                  0,0,DA2,0, 0,0,0,0));
`else
        vt.push_back(mk(1,IA0,1,0,DA2,0, 1,32'h77,         1,0,DA2,0, 0,0,1,32'h77));
        vt.push_back(mk(1,IA0,0,0,DA2,0, 1,32'h88,         1,0,IA0,0, 1,32'h88,0,0));
        vt.push_back(mk(0,0,0,0,0,0, 0,0,                  0,0,IA0,0, 0,0,0,0));
`endif
        for (int k = 0; k < vt.size(); k++) apply(vt[k], k);

        // Watchdog abort on a load that is never acked
        @(negedge clk);
        zero_inputs();
        d_req = 1'b1; d_addr = 32'h1000_0010; m_rdata = 32'hFFFF_FFFF;
        #1;
        chk("tmo idle m_req", 32'(m_req), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("tmo%0d m_req", k), 32'(m_req), 32'd1);
            chk($sformatf("tmo%0d d_ready", k), 32'(d_ready), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("tmo%0d d_rdata", k), d_rdata, 32'd0);
            chk($sformatf("tmo%0d err", k), 32'(err), 32'd0);
        end
        @(negedge clk);
        d_req = 1'b0; i_req = 1'b1; i_addr = IA0;
        #1;
        chk("tmo after m_req", 32'(m_req), 32'd0);
        chk("tmo after err", 32'(err), 32'd1);
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h0000_ABCD;
        #1;
        chk("tmo fetch m_addr", m_addr, IA0);
        chk("tmo fetch i_ready", 32'(i_ready), 32'd1);
        chk("tmo fetch i_rdata", i_rdata, 32'h0000_ABCD);
        chk("tmo fetch err", 32'(err), 32'd1);
        @(negedge clk);
        i_req = 1'b0; m_ack = 1'b0;
        #1;
        chk("tmo sticky err", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a store
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = DA0; d_wdata = DW;
        @(negedge clk);
        #1;
        chk("mid m_req busy", 32'(m_req), 32'd1);
        @(negedge clk);
        reset = 1'b0; m_ack = 1'b1; m_rdata = 32'h5555_5555;
        #1;
        chk("mid rst m_req", 32'(m_req), 32'd0);
        chk("mid rst d_ready", 32'(d_ready), 32'd0);
        chk("mid rst err", 32'(err), 32'd0);
        chk("mid rst m_addr", m_addr, 32'd0);
        chk("mid rst m_wdata", m_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1; m_ack = 1'b0;
        #1;
        chk("mid rel m_req", 32'(m_req), 32'd0);
        @(negedge clk);
        #1;
        chk("mid restart m_req", 32'(m_req), 32'd1);
        chk("mid restart m_addr", m_addr, DA0);
        chk("mid restart m_we", 32'(m_we), 32'd1);
        chk("mid restart m_wdata", m_wdata, DW);
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h6666_6666;
        #1;
        chk("mid restart d_ready", 32'(d_ready), 32'd1);
        chk("mid restart d_rdata", d_rdata, 32'h6666_6666);

        // Ack arriving on the last allowed cycle beats the watchdog
        @(negedge clk);
        zero_inputs();
        d_req = 1'b1; d_addr = 32'h1000_0020;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            m_ack = (k == 4); m_rdata = 32'h1234_5678;
            #1;
            chk($sformatf("race%0d d_ready", k), 32'(d_ready), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("race%0d d_rdata", k), d_rdata, (k == 4) ? 32'h1234_5678 : 32'd0);
        end
        @(negedge clk);
        zero_inputs();
        #1;
        chk("race err", 32'(err), 32'd0);
        chk("race m_req", 32'(m_req), 32'd0);

        // Randomized run against the reference model
        do_reset();
        own = 0; waited = 0; err_m = 1'b0; last_was_d = 1'b0;
        a_m = 32'd0; wd_m = 32'd0; we_m = 1'b0;
        begin
            bit i_pend, d_pend, busy, ack, tmo;
            int grant;
            logic        e_irdy, e_drdy;
            logic [31:0] e_irdata, e_drdata;
            i_pend = 1'b0; d_pend = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (!i_pend && $urandom_range(0, 2) == 0) begin
                    i_pend = 1'b1; i_addr = $urandom();
                end else if (i_pend && own != 1 && $urandom_range(0, 29) == 0) begin
                    i_pend = 1'b0;
                end
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    d_pend = 1'b1; d_addr = $urandom(); d_wdata = $urandom();
                    d_we = 1'($urandom_range(0, 1));
                end else if (d_pend && own != 2 && $urandom_range(0, 29) == 0) begin
                    d_pend = 1'b0;
                end
                i_req = i_pend; d_req = d_pend;
                m_ack = ($urandom_range(0, 99) < 40);
                m_rdata = $urandom();
                #1;
                busy = (own != 0);
                ack  = busy && m_ack;
                tmo  = busy && !m_ack && (waited + 1 == int'(TO));
                e_irdy   = (own == 1) && (ack || tmo);
                e_drdy   = (own == 2) && (ack || tmo);
                e_irdata = (own == 1 && ack) ? m_rdata : 32'd0;
                e_drdata = (own == 2 && ack) ? m_rdata : 32'd0;
                chk("rnd m_req", 32'(m_req), 32'(busy));
                chk("rnd m_addr", m_addr, a_m);
                chk("rnd m_we", 32'(m_we), busy ? 32'(we_m) : 32'd0);
                chk("rnd m_wdata", m_wdata, busy ? wd_m : 32'd0);
                chk("rnd i_ready", 32'(i_ready), 32'(e_irdy));
                chk("rnd i_rdata", i_rdata, e_irdata);
                chk("rnd d_ready", 32'(d_ready), 32'(e_drdy));
                chk("rnd d_rdata", d_rdata, e_drdata);
                chk("rnd err", 32'(err), 32'(err_m));
                if (busy && !ack && !tmo) begin
                    waited++;
                end else begin
                    if (!busy)          grant = pick_idle(i_req, d_req);
                    else if (ack)       grant = (own == 1) ? (d_req ? 2 : 0) : (i_req ? 1 : 0);
                    else                grant = 0;
                    if (tmo) err_m = 1'b1;
                    own = grant;
                    waited = 0;
                    if (grant == 1) begin
                        a_m = i_addr; we_m = 1'b0; wd_m = 32'd0; last_was_d = 1'b0;
                    end else if (grant == 2) begin
                        a_m = d_addr; we_m = d_we; wd_m = d_wdata; last_was_d = 1'b1;
                    end
                end
                if (e_irdy) i_pend = 1'b0;
                if (e_drdy) d_pend = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
